// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid geometry, apple-spawn FSM states,
// the cell-coordinate payload and the cell-to-pixel helper.
package snake_pkg;

  localparam int unsigned GRID_W  = 32;
  localparam int unsigned GRID_H  = 24;
  localparam int unsigned CELL_PX = 20;
  localparam int unsigned CELL_W  = 5;
  localparam int unsigned PIX_W   = 10;
  localparam int unsigned LFSR_W  = 10;
  localparam int unsigned SCORE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_QUERY,
    ST_SCAN,
    ST_COMMIT,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [CELL_W-1:0] cx;
    logic [CELL_W-1:0] cy;
  } cell_t;

  // c * 20 as (c << 4) + (c << 2); 31 * 20 = 620 fits in 10 bits
  function automatic logic [PIX_W-1:0] cell_to_px(input logic [CELL_W-1:0] c);
    return PIX_W'({c, 4'b0000}) + PIX_W'({c, 2'b00});
  endfunction

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, taps 10 and 7, with synchronous reload.
// Ports: clk, rst_n (async active-low), i_load (reload seed), o_q (state).
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  output logic [9:0] o_q
);

  logic [9:0] r_q;

  // Shift toward the MSB, feedback from bits 10 and 7 (1-based) into bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[8:0], r_q[9] ^ r_q[6]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer for the snake game: detects the head eating the
// apple, draws random candidate cells, checks them against the body store
// over a req/ack handshake, falls back to a raster scan, publishes the apple.
// Ports: clk, reset (async active-low), endgame (sync restart),
//        headx/heady (head pixel), occ_req/occ_cx/occ_cy/occ_ack/occ_hit
//        (occupancy query), applex/appley/apple_valid (apple to renderer),
//        eat (eaten pulse), score_cnt (saturating), board_full.
module apple_spawn_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 8,
  parameter logic [9:0]  LFSR_SEED = 10'h2A5,
  parameter int unsigned INIT_CX   = 10,
  parameter int unsigned INIT_CY   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               endgame,
  input  logic [PIX_W-1:0]   headx,
  input  logic [PIX_W-1:0]   heady,
  output logic               occ_req,
  output logic [CELL_W-1:0]  occ_cx,
  output logic [CELL_W-1:0]  occ_cy,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [PIX_W-1:0]   applex,
  output logic [PIX_W-1:0]   appley,
  output logic               apple_valid,
  output logic               eat,
  output logic [SCORE_W-1:0] score_cnt,
  output logic               board_full
);

  localparam int unsigned      TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [PIX_W-1:0] INIT_PX_X = cell_to_px(CELL_W'(INIT_CX));
  localparam logic [PIX_W-1:0] INIT_PX_Y = cell_to_px(CELL_W'(INIT_CY));

  state_e             r_state, w_state;
  logic [TRY_W-1:0]   r_try, w_try, w_try_inc;
  cell_t              r_cand, w_cand, w_cand_next, w_rand;
  logic               r_req, w_req;
  logic               r_eat, w_eat;
  logic [SCORE_W-1:0] r_score, w_score;
  logic               r_valid, w_valid;
  logic               r_full, w_full;
  logic [PIX_W-1:0]   r_applex, w_applex;
  logic [PIX_W-1:0]   r_appley, w_appley;
  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_head_on_apple, w_rand_bad, w_cand_is_head, w_cand_last;

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (endgame),
    .o_q    (w_lfsr)
  );

  // Inputs are cell-aligned, so pixel equality is cell equality
  assign w_head_on_apple = (headx == r_applex) && (heady == r_appley);
  assign w_rand          = cell_t'{cx: w_lfsr[4:0], cy: w_lfsr[9:5]};
  assign w_rand_bad      = (w_rand.cy >= CELL_W'(GRID_H)) ||
                           ((headx == cell_to_px(w_rand.cx)) && (heady == cell_to_px(w_rand.cy)));
  assign w_cand_is_head  = (headx == cell_to_px(r_cand.cx)) && (heady == cell_to_px(r_cand.cy));
  assign w_cand_last     = (r_cand.cx == CELL_W'(GRID_W - 1)) && (r_cand.cy == CELL_W'(GRID_H - 1));
  assign w_try_inc       = r_try + TRY_W'(1);

  // Raster order, x fastest
  assign w_cand_next = (r_cand.cx == CELL_W'(GRID_W - 1)) ?
                       cell_t'{cx: '0, cy: r_cand.cy + CELL_W'(1)} :
                       cell_t'{cx: r_cand.cx + CELL_W'(1), cy: r_cand.cy};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_try    <= '0;
      r_cand   <= '0;
      r_req    <= 1'b0;
      r_eat    <= 1'b0;
      r_score  <= '0;
      r_valid  <= 1'b1;
      r_full   <= 1'b0;
      r_applex <= INIT_PX_X;
      r_appley <= INIT_PX_Y;
    end else begin
      r_state  <= w_state;
      r_try    <= w_try;
      r_cand   <= w_cand;
      r_req    <= w_req;
      r_eat    <= w_eat;
      r_score  <= w_score;
      r_valid  <= w_valid;
      r_full   <= w_full;
      r_applex <= w_applex;
      r_appley <= w_appley;
    end
  end

  // Next-state and next-output logic; endgame overrides everything
  always_comb begin
    w_state  = r_state;
    w_try    = r_try;
    w_cand   = r_cand;
    w_req    = r_req;
    w_eat    = 1'b0;
    w_score  = r_score;
    w_valid  = r_valid;
    w_full   = r_full;
    w_applex = r_applex;
    w_appley = r_appley;

    if (endgame) begin
      w_state  = ST_IDLE;
      w_try    = '0;
      w_cand   = '0;
      w_req    = 1'b0;
      w_score  = '0;
      w_valid  = 1'b1;
      w_full   = 1'b0;
      w_applex = INIT_PX_X;
      w_appley = INIT_PX_Y;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_valid && w_head_on_apple) begin
            w_eat   = 1'b1;
            w_valid = 1'b0;
            w_try   = '0;
            w_state = ST_DRAW;
            if (r_score != '1) w_score = r_score + SCORE_W'(1);
          end
        end

        ST_DRAW: begin
          if (r_try >= TRY_W'(MAX_TRIES)) begin
            w_cand  = '0;
            w_state = ST_SCAN;
          end else if (w_rand_bad) begin
            w_try = w_try_inc;
          end else begin
            w_cand  = w_rand;
            w_req   = 1'b1;
            w_state = ST_QUERY;
          end
        end

        ST_QUERY: begin
          if (occ_ack) begin
            w_req = 1'b0;
            if (!occ_hit) begin
              w_state = ST_COMMIT;
            end else begin
              w_try = w_try_inc;
              if (w_try_inc >= TRY_W'(MAX_TRIES)) begin
                w_cand  = '0;
                w_state = ST_SCAN;
              end else begin
                w_state = ST_DRAW;
              end
            end
          end
        end

        // req low: issue (or skip the head cell); req high: await ack
        ST_SCAN: begin
          if (!r_req) begin
            if (w_cand_is_head) begin
              if (w_cand_last) begin
                w_full  = 1'b1;
                w_state = ST_HALT;
              end else begin
                w_cand = w_cand_next;
              end
            end else begin
              w_req = 1'b1;
            end
          end else if (occ_ack) begin
            w_req = 1'b0;
            if (!occ_hit) begin
              w_state = ST_COMMIT;
            end else if (w_cand_last) begin
              w_full  = 1'b1;
              w_state = ST_HALT;
            end else begin
              w_cand = w_cand_next;
            end
          end
        end

        ST_COMMIT: begin
          w_applex = cell_to_px(r_cand.cx);
          w_appley = cell_to_px(r_cand.cy);
          w_valid  = 1'b1;
          w_state  = ST_IDLE;
        end

        ST_HALT: begin
          w_valid = 1'b0;
          w_full  = 1'b1;
        end

        default: w_state = ST_IDLE;
      endcase
    end
  end

  assign occ_req     = r_req;
  assign occ_cx      = r_cand.cx;
  assign occ_cy      = r_cand.cy;
  assign applex      = r_applex;
  assign appley      = r_appley;
  assign apple_valid = r_valid;
  assign eat         = r_eat;
  assign score_cnt   = r_score;
  assign board_full  = r_full;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Directed self-checking bench for apple_spawn_ctrl.
module tb_apple_spawn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       endgame;
  logic [9:0] headx, heady;
  logic       occ_req;
  logic [4:0] occ_cx, occ_cy;
  logic       occ_ack, occ_hit;
  logic [9:0] applex, appley;
  logic       apple_valid, eat;
  logic [7:0] score_cnt;
  logic       board_full;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int eat_seen = 0;

  apple_spawn_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .endgame     (endgame),
    .headx       (headx),
    .heady       (heady),
    .occ_req     (occ_req),
    .occ_cx      (occ_cx),
    .occ_cy      (occ_cy),
    .occ_ack     (occ_ack),
    .occ_hit     (occ_hit),
    .applex      (applex),
    .appley      (appley),
    .apple_valid (apple_valid),
    .eat         (eat),
    .score_cnt   (score_cnt),
    .board_full  (board_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eat === 1'b1) eat_seen <= eat_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Poll at negedges until occ_req is high, bounded
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (occ_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Registered responder: ack one cycle after the request was seen
  task automatic give_ack(input logic hit);
    @(negedge clk);
    occ_ack = 1'b1;
    occ_hit = hit;
    @(negedge clk);
    occ_ack = 1'b0;
    occ_hit = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0, rq, nscan, head_q, e0, tmo;
    bit scan_seen;

    reset = 1'b0; endgame = 1'b0; headx = 10'd0; heady = 10'd0;
    occ_ack = 1'b0; occ_hit = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_applex", 32'(applex), 200);
    check("rst_appley", 32'(appley), 240);
    check("rst_valid", 32'(apple_valid), 1);
    check("rst_score", 32'(score_cnt), 0);
    check("rst_req", 32'(occ_req), 0);
    check("rst_full", 32'(board_full), 0);
    check("rst_eat", 32'(eat), 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_valid", 32'(apple_valid), 1);
    check("idle_req", 32'(occ_req), 0);

    // First eat; LFSR after 3 steps from 0x2A5 is 0x12F -> candidate (15,9)
    headx = 10'd200; heady = 10'd240;
    c0 = cyc;
    @(negedge clk);
    check("eat_pulse", 32'(eat), 1);
    check("eat_score", 32'(score_cnt), 1);
    check("eat_valid_low", 32'(apple_valid), 0);
    check("draw_req_low", 32'(occ_req), 0);
    @(negedge clk);
    check("eat_one_cycle", 32'(eat), 0);
    check("query_req", 32'(occ_req), 1);
    check("query_cx", 32'(occ_cx), 15);
    check("query_cy", 32'(occ_cy), 9);
    @(negedge clk);
    check("query_req_held", 32'(occ_req), 1);
    check("query_cx_held", 32'(occ_cx), 15);
    occ_ack = 1'b1; occ_hit = 1'b0;
    @(negedge clk);
    occ_ack = 1'b0;
    check("req_drop_after_ack", 32'(occ_req), 0);
    check("commit_valid_low", 32'(apple_valid), 0);
    @(negedge clk);
    check("place_valid", 32'(apple_valid), 1);
    check("place_applex", 32'(applex), 300);
    check("place_appley", 32'(appley), 180);
    check("place_latency", 32'(cyc - c0), 5);

    // Random candidates all hit -> raster scan from (0,0); (3,0) free
    headx = 10'd300; heady = 10'd180;
    @(negedge clk);
    check("eat2_pulse", 32'(eat), 1);
    check("eat2_score", 32'(score_cnt), 2);
    rq = 0; scan_seen = 1'b0; ok = 1'b1;
    for (int q = 0; q < 12 && !scan_seen && ok; q++) begin
      wait_req(ok);
      if (ok) begin
        if (occ_cx == 5'd0 && occ_cy == 5'd0) scan_seen = 1'b1;
        else begin
          rq++;
          give_ack(1'b1);
        end
      end
    end
    check("scan_reached", 32'(scan_seen), 1);
    check("rand_queries_le_max", 32'(rq <= 8), 1);
    for (int x = 0; x < 4; x++) begin
      wait_req(ok);
      check("scan_req", 32'(ok), 1);
      check("scan_cx", 32'(occ_cx), 32'(x));
      check("scan_cy", 32'(occ_cy), 0);
      give_ack(x != 3);
    end
    tmo = 0;
    while (apple_valid !== 1'b1 && tmo < 10) begin
      @(negedge clk);
      tmo++;
    end
    check("scan_valid", 32'(apple_valid), 1);
    check("scan_applex", 32'(applex), 60);
    check("scan_appley", 32'(appley), 0);

    // Everything occupied -> full scan, head cell (3,0) skipped, HALT
    headx = 10'd60; heady = 10'd0;
    @(negedge clk);
    check("eat3_pulse", 32'(eat), 1);
    check("eat3_score", 32'(score_cnt), 3);
    scan_seen = 1'b0; nscan = 0; head_q = 0; ok = 1'b1;
    for (int q = 0; q < 1000 && board_full !== 1'b1 && ok; q++) begin
      wait_req(ok);
      if (ok) begin
        if (occ_cx == 5'd0 && occ_cy == 5'd0) scan_seen = 1'b1;
        if (scan_seen) begin
          nscan++;
          if (occ_cx == 5'd3 && occ_cy == 5'd0) head_q++;
        end
        give_ack(1'b1);
      end
    end
    check("full_handshake", 32'(ok), 1);
    check("full_flag", 32'(board_full), 1);
    check("full_valid", 32'(apple_valid), 0);
    check("full_req", 32'(occ_req), 0);
    check("full_scan_count", 32'(nscan), 767);
    check("full_head_skipped", 32'(head_q), 0);
    // Head sits on the stale apple pixel while invalid: must not eat
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halt_no_eat", 32'(eat), 0);
    end
    check("halt_score", 32'(score_cnt), 3);
    check("halt_hold", 32'(board_full), 1);

    // Endgame restart
    endgame = 1'b1;
    @(negedge clk);
    endgame = 1'b0;
    check("eg_full", 32'(board_full), 0);
    check("eg_valid", 32'(apple_valid), 1);
    check("eg_applex", 32'(applex), 200);
    check("eg_appley", 32'(appley), 240);
    check("eg_score", 32'(score_cnt), 0);
    check("eg_req", 32'(occ_req), 0);

    // Async reset mid-query, then a stale ack
    headx = 10'd200; heady = 10'd240;
    @(negedge clk);
    check("eat4_pulse", 32'(eat), 1);
    wait_req(ok);
    check("mid_query_req", 32'(ok), 1);
    headx = 10'd0; heady = 10'd0;
    reset = 1'b0;
    #1;
    check("async_req_low", 32'(occ_req), 0);
    check("async_valid", 32'(apple_valid), 1);
    check("async_score", 32'(score_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    occ_ack = 1'b1; occ_hit = 1'b0;
    @(negedge clk);
    occ_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_valid", 32'(apple_valid), 1);
    check("late_ack_applex", 32'(applex), 200);
    check("late_ack_appley", 32'(appley), 240);
    check("late_ack_req", 32'(occ_req), 0);
    check("late_ack_score", 32'(score_cnt), 0);

    // 300 eats with the head parked on each eaten cell
    #1;
    e0 = eat_seen;
    tmo = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      headx = applex; heady = appley;
      @(negedge clk);
      for (int k = 0; k < 100 && apple_valid !== 1'b1; k++) begin
        if (occ_req === 1'b1) give_ack(1'b0);
        else @(negedge clk);
      end
      if (apple_valid !== 1'b1) tmo++;
      repeat (2) @(negedge clk);
    end
    #1;
    check("sat_no_timeout", 32'(tmo), 0);
    check("sat_score", 32'(score_cnt), 255);
    check("sat_eat_pulses", 32'(eat_seen - e0), 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apple_spawn_ctrl.md
Name: apple_spawn_ctrl

Overview:
- Controller that sequences apple placement for the VGA snake game on a 32x24 grid of 20-pixel cells (640x480).
- Detects the head eating the apple and draws a pseudo-random candidate cell from an internal LFSR.
- Asks the body-occupancy store whether the candidate cell is free, using a req/ack handshake, and retries on a hit.
- Falls back to a raster scan when random retries run out. Publishes apple pixel coordinates and the score to the renderer.

Parameters:
- GRID_W, 32, grid columns (5-bit cell x).
- GRID_H, 24, grid rows (5-bit cell y).
- CELL_PX, 20, pixels per cell.
- MAX_TRIES, 8, random candidates allowed before raster fallback.
- LFSR_SEED, 10'h2A5, non-zero LFSR reset value.
- INIT_CX, 10, initial apple cell x.
- INIT_CY, 12, initial apple cell y.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- endgame  in  1  synchronous game restart, same effect as reset.
- headx  in  10  snake head pixel x, cell-aligned.
- heady  in  10  snake head pixel y, cell-aligned.
- occ_req  out  1  occupancy query request.
- occ_cx  out  5  queried cell x.
- occ_cy  out  5  queried cell y.
- occ_ack  in  1  one-cycle query response strobe.
- occ_hit  in  1  cell occupied by body; valid with occ_ack.
- applex  out  10  apple pixel x (cell x * CELL_PX).
- appley  out  10  apple pixel y (cell y * CELL_PX).
- apple_valid  out  1  apple placed and drawable.
- eat  out  1  one-cycle pulse when the apple is eaten.
- score_cnt  out  8  apples eaten, saturating.
- board_full  out  1  no free cell exists.

Behaviour:
- Reset (reset low, asynchronous) and endgame (synchronous):
  - state=IDLE; apple cell=(INIT_CX,INIT_CY), i.e. applex=200, appley=240; apple_valid=1.
  - score_cnt=0, eat=0, occ_req=0, board_full=0; LFSR=LFSR_SEED; try count=0.
  - Both abort any in-flight query. A late occ_ack is ignored in IDLE.
- Head cell = headx/CELL_PX, heady/CELL_PX. Inputs are cell-aligned, so this is an exact divide; implement it as a comparison of headx against applex.
- LFSR: 10-bit Fibonacci, taps 10,7. Advances every cycle in every state, including HALT.
- States:
  - IDLE:
    - If apple_valid and head cell == apple cell, then next cycle: eat=1; score_cnt+1, saturating at 255; apple_valid=0; try count=0; -> DRAW.
  - DRAW:
    - Candidate cx=LFSR[4:0], cy=LFSR[9:5].
    - Reject without querying if cy>=GRID_H or the candidate equals the current head cell. A reject increments the try count and stays in DRAW.
    - Otherwise latch the candidate and go to QUERY.
    - If the try count reaches MAX_TRIES, -> SCAN with scan cell=(0,0).
  - QUERY:
    - occ_req=1, with occ_cx/occ_cy held stable until occ_ack.
    - On occ_ack with occ_hit=0 -> COMMIT.
    - On occ_ack with occ_hit=1: try count+1, -> DRAW, or -> SCAN if the count is now MAX_TRIES.
    - occ_req deasserts the cycle after occ_ack. No timeout.
  - SCAN:
    - Queries cells in raster order (x fastest) with the same handshake, skipping the head cell.
    - The first cell with occ_hit=0 -> COMMIT.
    - After the hit on cell (31,23), board_full=1 -> HALT.
  - COMMIT:
    - applex=cx*CELL_PX, appley=cy*CELL_PX, computed as (c<<4)+(c<<2), 10-bit, max 620/460.
    - apple_valid=1; -> IDLE.
  - HALT:
    - apple_valid=0; board_full=1; held until reset or endgame.
- Simultaneous events:
  - endgame in any state wins over ack and eat.
  - A head overlapping the apple while apple_valid=0 never counts.
- Latency:
  - Eat to eat pulse: 1 cycle.
  - Best-case eat to apple_valid: 5 cycles (IDLE, DRAW, QUERY, ack, COMMIT) with 0-wait ack.
- applex/appley hold their old value while apple_valid=0.

Decomposition:
- Shared package snake_pkg: GRID_W, GRID_H, CELL_PX, the state enum, and a cell struct {cx[4:0], cy[4:0]}.
- One natural sub-module: lfsr10 (free-running, seedable, async active-low reset).

Test Plan:
- Reset release, head at (0,0) -> applex=200, appley=240, apple_valid=1, score_cnt=0, occ_req=0.
- Head to (200,240), ack after 0 waits with hit=0 -> eat pulses one cycle, score_cnt=1, new apple on a 20-px grid with appley<=460, apple_valid rises 5 cycles after the match.
- Responder returns hit=1 for 8 consecutive queries -> SCAN starts at cell (0,0). Free cell (3,0) -> applex=60, appley=0.
- Responder always hit=1 -> board_full=1 after the scan of (31,23), apple_valid=0; then endgame pulse -> board_full=0, apple at (200,240), score_cnt=0.
- Assert reset low while occ_req=1 mid-QUERY -> occ_req=0 immediately (asynchronous). A later ack produces no state change.
- 300 eats in a row -> score_cnt saturates at 255. Head held on the apple cell over several cycles -> exactly one eat pulse per apple.
